// File: rtl/breakout_result_buffer_if.sv
// Handshake bundle between the breakout stage, the result buffer and its
// consumer.
//   in_*    : producer -> buffer valid/ready word transfer
//   out_*   : buffer -> consumer valid/ready word transfer
//   sum_clr : clears the delivered-word running sum
//   count   : buffer occupancy, 0..DEPTH
//   sum_out : running sum of delivered words, modulo 2^SUM_W
// slave is the buffer's view. master is the producer/consumer view.
interface breakout_result_buffer_if #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = 10
);
    logic [DATA_W-1:0]         in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sum_clr;
    logic [$clog2(DEPTH):0]    count;
    logic [SUM_W-1:0]          sum_out;

    modport slave (
        input  in_data, in_valid, out_ready, sum_clr,
        output in_ready, out_data, out_valid, count, sum_out
    );

    modport master (
        output in_data, in_valid, out_ready, sum_clr,
        input  in_ready, out_data, out_valid, count, sum_out
    );
endinterface

// File: rtl/breakout_result_buffer.sv
// Result buffer behind the breakout block.
// It is a DEPTH-entry FIFO with valid/ready on both sides. It also keeps a
// running sum of every word that is handed to the consumer.
//   clk : rising-edge clock
//   rst : synchronous active-high reset. It clears the pointers, the count
//         and the sum. Memory contents are kept.
//   bus : slave view of breakout_result_buffer_if (handshakes, count, sum)
// All flags are decoded from registered state, so there is no combinational
// path from the input side to the output side.
module breakout_result_buffer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    breakout_result_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              in_ready, out_valid, push, pop;
    logic [DATA_W-1:0] out_data;

    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        push      = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
    end

    always_comb begin
        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The clear is applied first, so a clear with a pop leaves only the
        // popped word in the sum.
        sum_d = bus.sum_clr ? '0 : sum_q;
        if (pop) begin
            sum_d = sum_d + SUM_W'(out_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
        end
    end

    // Storage is not reset. The pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.count     = count_q;
    assign bus.sum_out   = sum_q;
endmodule
